disc_drop_ctrl: RTL and testbench

Parametrised successor to the fixed-position token block. It tracks the active player's hovering disc above the board and moves it between columns from keyboard input. On a drop command it animates the disc falling, one step per frame, to the lowest free row of the selected column. It reports the landing cell to the board-state logic and drives the disc X/Y coordinates consumed by the colour mapper.

---
 rtl/disc_drop_ctrl.sv | 178 +++++++++++++++++
 tb/tb_disc_drop_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/disc_drop_ctrl.sv
// Hovering-disc column selector and drop animator; reports the landing cell.
// Optional: define GRAVITY_ACCEL_EN for an accelerating fall instead of constant DROP_STEP.
module disc_drop_ctrl #(
    parameter int          COLS      = 7,
    parameter int          ROWS      = 6,
    parameter int          X0        = 75,
    parameter int          Y0        = 75,
    parameter int          CELL      = 50,
    parameter int          DROP_STEP = 5,
    parameter logic [7:0]  KEY_LEFT  = 8'h04,
    parameter logic [7:0]  KEY_RIGHT = 8'h07,
    parameter logic [7:0]  KEY_DROP  = 8'h2C
) (
    input  logic                frame_clk,
    input  logic                Reset,
    input  logic [7:0]          keycode,
    input  logic                drop_en,
    input  logic [3*COLS-1:0]   col_count,
    output logic [9:0]          DiscX,
    output logic [9:0]          DiscY,
    output logic                disc_player,
    output logic                busy,
    output logic                land_pulse,
    output logic [3:0]          land_col,
    output logic [2:0]          land_row
);

    typedef enum logic [1:0] {IDLE, FALL, LAND} state_t;

    localparam logic [3:0] COL_RST = 4'(COLS / 2);
    localparam logic [3:0] COL_MAX = 4'(COLS - 1);
    localparam logic [2:0] ROWS_L  = 3'(ROWS);
    localparam logic [2:0] ROW_MAX = 3'(ROWS - 1);
    localparam logic [9:0] HOVER_Y = 10'(Y0 - CELL);
    localparam logic [9:0] X_RST   = 10'(X0 + (COLS / 2) * CELL);

    state_t     state_q, state_d;
    logic [3:0] sel_col_q, sel_col_d;
    logic [9:0] disc_x_q, disc_x_d;
    logic [9:0] disc_y_q, disc_y_d;
    logic       player_q, player_d;
    logic       busy_q, busy_d;
    logic       land_pulse_q, land_pulse_d;
    logic [3:0] land_col_q, land_col_d;
    logic [2:0] land_row_q, land_row_d;
    logic [7:0] prev_key_q;
    logic [2:0] target_row_q, target_row_d;
    logic [9:0] target_y_q, target_y_d;

    logic       key_new;
    logic [2:0] sel_count;
    logic [10:0] step_w;
    logic [10:0] y_sum;

`ifdef GRAVITY_ACCEL_EN
    localparam logic [9:0] VEL_MAX = 10'(CELL);
    logic [9:0] vel_q, vel_d;
`endif

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            sel_col_q    <= COL_RST;
            disc_x_q     <= X_RST;
            disc_y_q     <= HOVER_Y;
            player_q     <= 1'b0;
            busy_q       <= 1'b0;
            land_pulse_q <= 1'b0;
            land_col_q   <= 4'd0;
            land_row_q   <= 3'd0;
            prev_key_q   <= 8'd0;
            target_row_q <= 3'd0;
            target_y_q   <= 10'd0;
        end else begin
            state_q      <= state_d;
            sel_col_q    <= sel_col_d;
            disc_x_q     <= disc_x_d;
            disc_y_q     <= disc_y_d;
            player_q     <= player_d;
            busy_q       <= busy_d;
            land_pulse_q <= land_pulse_d;
            land_col_q   <= land_col_d;
            land_row_q   <= land_row_d;
            prev_key_q   <= keycode;
            target_row_q <= target_row_d;
            target_y_q   <= target_y_d;
        end
    end

`ifdef GRAVITY_ACCEL_EN
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) vel_q <= 10'd1;
        else       vel_q <= vel_d;
    end
`endif

    // Count of discs already in the selected column.
    always_comb begin
        sel_count = 3'd0;
        for (int c = 0; c < COLS; c++) begin
            if (sel_col_q == 4'(c)) sel_count = col_count[3*c +: 3];
        end
    end

`ifdef GRAVITY_ACCEL_EN
    assign step_w = {1'b0, vel_q};
`else
    assign step_w = 11'(DROP_STEP);
`endif
    assign y_sum   = {1'b0, disc_y_q} + step_w;
    assign key_new = (keycode != prev_key_q);

    always_comb begin
        state_d      = state_q;
        sel_col_d    = sel_col_q;
        disc_y_d     = disc_y_q;
        player_d     = player_q;
        land_pulse_d = 1'b0;
        land_col_d   = land_col_q;
        land_row_d   = land_row_q;
        target_row_d = target_row_q;
        target_y_d   = target_y_q;
`ifdef GRAVITY_ACCEL_EN
        vel_d        = vel_q;
`endif
        case (state_q)
            IDLE: begin
                if (drop_en && key_new) begin
                    if (keycode == KEY_LEFT) begin
                        sel_col_d = (sel_col_q == 4'd0) ? COL_MAX : sel_col_q - 4'd1;
                    end else if (keycode == KEY_RIGHT) begin
                        sel_col_d = (sel_col_q == COL_MAX) ? 4'd0 : sel_col_q + 4'd1;
                    end else if (keycode == KEY_DROP && sel_count < ROWS_L) begin
                        target_row_d = ROW_MAX - sel_count;
                        target_y_d   = 10'(Y0 + int'(target_row_d) * CELL);
                        state_d      = FALL;
`ifdef GRAVITY_ACCEL_EN
                        vel_d        = 10'd1;
`endif
                    end
                end
            end
            FALL: begin
                if (y_sum >= {1'b0, target_y_q}) begin
                    disc_y_d     = target_y_q;
                    state_d      = LAND;
                    land_pulse_d = 1'b1;
                    land_col_d   = sel_col_q;
                    land_row_d   = target_row_q;
                end else begin
                    disc_y_d = y_sum[9:0];
                end
`ifdef GRAVITY_ACCEL_EN
                vel_d = (vel_q >= VEL_MAX) ? VEL_MAX : vel_q + 10'd1;
`endif
            end
            LAND: begin
                state_d  = IDLE;
                disc_y_d = HOVER_Y;
                player_d = ~player_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // X tracks the selection in the same frame as the command, so derive it from the next value.
    assign disc_x_d = 10'(X0 + int'(sel_col_d) * CELL);
    assign busy_d   = (state_d != IDLE);

    assign DiscX       = disc_x_q;
    assign DiscY       = disc_y_q;
    assign disc_player = player_q;
    assign busy        = busy_q;
    assign land_pulse  = land_pulse_q;
    assign land_col    = land_col_q;
    assign land_row    = land_row_q;

endmodule

// File: tb/tb_disc_drop_ctrl.sv
// Directed bench for disc_drop_ctrl: vector table for selection, hand sequences for drops and reset.
module tb_disc_drop_ctrl;

    localparam logic [7:0] K_L = 8'h04;
    localparam logic [7:0] K_R = 8'h07;
    localparam logic [7:0] K_D = 8'h2C;

    logic        frame_clk = 1'b0;
    logic        Reset;
    logic [7:0]  keycode;
    logic        drop_en;
    logic [20:0] col_count;
    logic [9:0]  DiscX, DiscY;
    logic        disc_player, busy, land_pulse;
    logic [3:0]  land_col;
    logic [2:0]  land_row;

    int n_vec = 0;
    int n_err = 0;

    disc_drop_ctrl dut (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .keycode    (keycode),
        .drop_en    (drop_en),
        .col_count  (col_count),
        .DiscX      (DiscX),
        .DiscY      (DiscY),
        .disc_player(disc_player),
        .busy       (busy),
        .land_pulse (land_pulse),
        .land_col   (land_col),
        .land_row   (land_row)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        logic [7:0] key;
        logic       en;
        int         x;
        int         y;
        int         bsy;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge frame_clk);
        #1;
    endtask

`ifdef GRAVITY_ACCEL_EN
    localparam int EDGES_ROW5 = 25;
    localparam int EDGES_ROW3 = 21;
`else
    localparam int EDGES_ROW5 = 61;
    localparam int EDGES_ROW3 = 41;
`endif

    // Drop from the current column and follow the fall to landing.
    task automatic run_drop(input string nm, input int tgt, input int col, input int row,
                            input int edges_exp, input int player_after);
        int y, v, ny, edges;
        bit landed;
        keycode = K_D;
        step();
        edges = 1;
        y = 25;
        v = 1;
        chk({nm, " busy on entry"}, busy, 1);
        chk({nm, " y on entry"}, DiscY, 25);
        keycode = 8'd0;
        landed = 0;
        while (!landed && edges < 300) begin
            step();
            edges++;
`ifdef GRAVITY_ACCEL_EN
            ny = y + v;
            v = (v + 1 > 50) ? 50 : v + 1;
`else
            ny = y + 5;
`endif
            y = (ny >= tgt) ? tgt : ny;
            if (DiscY != y) chk({nm, " fall y"}, DiscY, y);
            if (busy !== 1'b1) chk({nm, " busy during fall"}, busy, 1);
            if (land_pulse) landed = 1;
        end
        chk({nm, " landed"}, landed, 1);
        chk({nm, " edges to pulse"}, edges, edges_exp);
        chk({nm, " y at land"}, DiscY, tgt);
        chk({nm, " land_col"}, land_col, col);
        chk({nm, " land_row"}, land_row, row);
        step();
        chk({nm, " pulse width"}, land_pulse, 0);
        chk({nm, " busy after"}, busy, 0);
        chk({nm, " hover y after"}, DiscY, 25);
        chk({nm, " player after"}, disc_player, player_after);
        chk({nm, " land_row held"}, land_row, row);
    endtask

    task automatic press(input logic [7:0] k);
        keycode = k;
        step();
        keycode = 8'd0;
        step();
    endtask

    vec_t vecs[17];

    initial begin
        vecs[0]  = '{8'd0, 1'b1, 225, 25, 0};
        vecs[1]  = '{K_R,  1'b1, 275, 25, 0};
        vecs[2]  = '{8'd0, 1'b1, 275, 25, 0};
        vecs[3]  = '{K_R,  1'b1, 325, 25, 0};
        vecs[4]  = '{8'd0, 1'b1, 325, 25, 0};
        vecs[5]  = '{K_R,  1'b1, 375, 25, 0};
        vecs[6]  = '{8'd0, 1'b1, 375, 25, 0};
        vecs[7]  = '{K_R,  1'b1, 75,  25, 0};
        vecs[8]  = '{8'd0, 1'b1, 75,  25, 0};
        vecs[9]  = '{K_L,  1'b1, 375, 25, 0};
        vecs[10] = '{8'd0, 1'b1, 375, 25, 0};
        vecs[11] = '{K_L,  1'b1, 325, 25, 0};
        vecs[12] = '{8'd0, 1'b0, 325, 25, 0};
        vecs[13] = '{K_L,  1'b0, 325, 25, 0};
        vecs[14] = '{8'd0, 1'b0, 325, 25, 0};
        vecs[15] = '{K_D,  1'b0, 325, 25, 0};
        vecs[16] = '{8'd0, 1'b1, 325, 25, 0};

        Reset = 1'b1;
        keycode = 8'd0;
        drop_en = 1'b1;
        col_count = '0;
        #2;
        chk("reset DiscX", DiscX, 225);
        chk("reset DiscY", DiscY, 25);
        chk("reset player", disc_player, 0);
        chk("reset busy", busy, 0);
        chk("reset land_pulse", land_pulse, 0);
        chk("reset land_col", land_col, 0);
        chk("reset land_row", land_row, 0);
        step();
        Reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            keycode = vecs[i].key;
            drop_en = vecs[i].en;
            step();
            chk($sformatf("vec%0d DiscX", i), DiscX, vecs[i].x);
            chk($sformatf("vec%0d DiscY", i), DiscY, vecs[i].y);
            chk($sformatf("vec%0d busy", i), busy, vecs[i].bsy);
            chk($sformatf("vec%0d land_pulse", i), land_pulse, 0);
        end

        // Held RIGHT advances once: col 5 -> 6.
        keycode = K_R;
        for (int i = 0; i < 10; i++) step();
        chk("held right DiscX", DiscX, 375);
        keycode = 8'd0;
        step();
        chk("held right release", DiscX, 375);

        // Back to a fresh column 3.
        Reset = 1'b1;
        #2;
        Reset = 1'b0;
        step();
        chk("re-reset DiscX", DiscX, 225);

        run_drop("col3 empty", 325, 3, 5, EDGES_ROW5, 1);

        // Column 0 with two discs lands in row 3.
        press(K_L);
        press(K_L);
        press(K_L);
        chk("at col0 DiscX", DiscX, 75);
        col_count = 21'd2;
        run_drop("col0 cnt2", 225, 0, 3, EDGES_ROW3, 0);

        // Full column 6: drop ignored.
        press(K_L);
        chk("at col6 DiscX", DiscX, 375);
        col_count = 21'd6 << 18;
        keycode = K_D;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("full col busy f%0d", i), busy, 0);
            chk($sformatf("full col pulse f%0d", i), land_pulse, 0);
        end
        keycode = 8'd0;
        step();
        chk("full col DiscY", DiscY, 25);
        chk("full col player", disc_player, 0);
        chk("full col land_col held", land_col, 0);

        // Asynchronous reset mid-fall.
        col_count = '0;
        keycode = K_D;
        step();
        keycode = 8'd0;
        step();
        step();
        chk("pre-reset busy", busy, 1);
        #2;
        Reset = 1'b1;
        #1;
        chk("async rst DiscX", DiscX, 225);
        chk("async rst DiscY", DiscY, 25);
        chk("async rst busy", busy, 0);
        chk("async rst pulse", land_pulse, 0);
        chk("async rst player", disc_player, 0);
        step();
        Reset = 1'b0;
        step();
        chk("post rst busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
